// File: rtl/hls_stage_sequencer.sv
// ---------------------------------------------------------------------------
// hls_stage_sequencer
//
// ap_ctrl_hs sequencer for the DDR-bandwidth experiment top. One top-level
// start launches a run over the stages selected in stage_mask. Those stages
// are started strictly in ascending index order, one at a time. Per-stage and
// total cycle counts are kept so each run can be measured on hardware.
//
// Handshake (ap_ctrl_hs, both towards the host and towards each stage):
//   start is held high until ready is seen high in the same cycle; that cycle
//   is the acceptance. done is a single-cycle completion pulse that may
//   coincide with the acceptance cycle.
//
// Ports:
//   clock, reset        single rising-edge clock, synchronous active-high reset
//   ap_start            top-level start request
//   ap_ready            high in the cycle ap_start is accepted (IDLE & ap_start)
//   ap_done             one-cycle pulse when the run completes
//   ap_idle             high in IDLE only
//   stage_mask          bit i selects stage i, sampled at acceptance
//   stage_start         one-hot ap_start to the active stage
//   stage_ready         per-stage ap_ready
//   stage_done          per-stage ap_done
//   cur_stage           index of the active / last selected stage
//   stage_cycles        latched cycles per stage, stage i at [i*CNT_W +: CNT_W]
//   total_cycles        non-IDLE cycles of the current / last run
//   err_spurious        sticky: stage_done seen from a stage that is not active
//   dbg_state           current FSM state, for checkers
// ---------------------------------------------------------------------------
module hls_stage_sequencer #(
    parameter int NUM_STAGES = 5,
    parameter int CNT_W      = 32,
    parameter int IDX_W      = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        ap_start,
    output logic                        ap_ready,
    output logic                        ap_done,
    output logic                        ap_idle,
    input  logic [NUM_STAGES-1:0]       stage_mask,
    output logic [NUM_STAGES-1:0]       stage_start,
    input  logic [NUM_STAGES-1:0]       stage_ready,
    input  logic [NUM_STAGES-1:0]       stage_done,
    output logic [IDX_W-1:0]            cur_stage,
    output logic [NUM_STAGES*CNT_W-1:0] stage_cycles,
    output logic [CNT_W-1:0]            total_cycles,
    output logic                        err_spurious,
    output logic [2:0]                  dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_SELECT    = 3'd1,
        S_START     = 3'd2,
        S_WAIT_DONE = 3'd3,
        S_FINISH    = 3'd4
    } state_t;

    state_t                             state_q;
    logic [NUM_STAGES-1:0]              pend_mask_q;
    logic [IDX_W-1:0]                   cur_stage_q;
    logic [NUM_STAGES-1:0]              stage_start_q;
    logic                               ap_done_q;
    logic                               ap_idle_q;
    logic                               err_q;
    logic [CNT_W-1:0]                   stage_cnt_q;
    logic [CNT_W-1:0]                   total_q;
    logic [NUM_STAGES-1:0][CNT_W-1:0]   stage_cycles_q;

    logic [NUM_STAGES-1:0] cur_onehot;
    logic [NUM_STAGES-1:0] sel_onehot;
    logic [IDX_W-1:0]      sel_idx;
    logic                  ready_cur;
    logic                  done_cur;
    logic                  spurious;
    logic [CNT_W-1:0]      stage_cnt_d;
    logic [CNT_W-1:0]      total_d;

    // Decode of the active stage and the lowest pending stage.
    always_comb begin
        cur_onehot = '0;
        sel_idx    = '0;
        for (int i = 0; i < NUM_STAGES; i++) begin
            cur_onehot[i] = (cur_stage_q == IDX_W'(i));
        end
        // Scan downwards so the lowest set bit is the last one written.
        for (int i = NUM_STAGES - 1; i >= 0; i--) begin
            if (pend_mask_q[i]) begin
                sel_idx = IDX_W'(i);
            end
        end
    end

    // Isolate the lowest set bit of the pending mask.
    assign sel_onehot = pend_mask_q & (~pend_mask_q + NUM_STAGES'(1));

    assign ready_cur = |(stage_ready & cur_onehot);
    assign done_cur  = |(stage_done & cur_onehot);

    // Only the active stage may report done, and only while it is running.
    always_comb begin
        spurious = 1'b0;
        case (state_q)
            S_START, S_WAIT_DONE: spurious = |(stage_done & ~cur_onehot);
            default:              spurious = |stage_done;
        endcase
    end

    // Saturating increments.
    assign stage_cnt_d = (&stage_cnt_q) ? stage_cnt_q : stage_cnt_q + CNT_W'(1);
    assign total_d     = (&total_q)     ? total_q     : total_q + CNT_W'(1);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q        <= S_IDLE;
            pend_mask_q    <= '0;
            cur_stage_q    <= '0;
            stage_start_q  <= '0;
            ap_done_q      <= 1'b0;
            ap_idle_q      <= 1'b1;
            err_q          <= 1'b0;
            stage_cnt_q    <= '0;
            total_q        <= '0;
            stage_cycles_q <= '0;
        end else begin
            ap_done_q <= 1'b0;
            if (state_q != S_IDLE) begin
                total_q <= total_d;
            end
            if (spurious) begin
                err_q <= 1'b1;
            end

            case (state_q)
                S_IDLE: begin
                    if (ap_start) begin
                        pend_mask_q    <= stage_mask;
                        stage_cycles_q <= '0;
                        total_q        <= '0;
                        // Acceptance clears the sticky error, overriding any set above.
                        err_q          <= 1'b0;
                        ap_idle_q      <= 1'b0;
                        state_q        <= S_SELECT;
                    end
                end
                S_SELECT: begin
                    if (pend_mask_q == '0) begin
                        ap_done_q <= 1'b1;
                        state_q   <= S_FINISH;
                    end else begin
                        cur_stage_q   <= sel_idx;
                        stage_cnt_q   <= '0;
                        stage_start_q <= sel_onehot;
                        state_q       <= S_START;
                    end
                end
                S_START: begin
                    stage_cnt_q <= stage_cnt_d;
                    if (ready_cur) begin
                        stage_start_q <= '0;
                        if (done_cur) begin
                            for (int i = 0; i < NUM_STAGES; i++) begin
                                if (cur_onehot[i]) begin
                                    stage_cycles_q[i] <= stage_cnt_d;
                                end
                            end
                            pend_mask_q <= pend_mask_q & ~cur_onehot;
                            state_q     <= S_SELECT;
                        end else begin
                            state_q <= S_WAIT_DONE;
                        end
                    end
                end
                S_WAIT_DONE: begin
                    stage_cnt_q <= stage_cnt_d;
                    if (done_cur) begin
                        for (int i = 0; i < NUM_STAGES; i++) begin
                            if (cur_onehot[i]) begin
                                stage_cycles_q[i] <= stage_cnt_d;
                            end
                        end
                        pend_mask_q <= pend_mask_q & ~cur_onehot;
                        state_q     <= S_SELECT;
                    end
                end
                S_FINISH: begin
                    ap_idle_q <= 1'b1;
                    state_q   <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign ap_ready     = ap_idle_q & ap_start;
    assign ap_done      = ap_done_q;
    assign ap_idle      = ap_idle_q;
    assign stage_start  = stage_start_q;
    assign cur_stage    = cur_stage_q;
    assign stage_cycles = stage_cycles_q;
    assign total_cycles = total_q;
    assign err_spurious = err_q;
    assign dbg_state    = state_q;

endmodule

// File: doc/hls_stage_sequencer.md
# hls_stage_sequencer

Synthesizable ap_ctrl_hs sequencer for the DDR-bandwidth experiment top. It accepts one top-level start, then runs a masked subset of NUM_STAGES sub-pipelines (load, compute, store, …) strictly in index order using their ap_start/ap_ready/ap_done handshakes. It records per-stage and total cycle counts so each run can be measured on hardware without co-simulation.

## Interface
Parameters:
- NUM_STAGES, 5, number of sequenced sub-pipelines (1..16)
- CNT_W, 32, width of each cycle counter
- IDX_W, $clog2(NUM_STAGES) min 1, width of cur_stage

Ports:
- clock  in  1  single clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- ap_start  in  1  top-level start request
- ap_ready  out  1  one-cycle pulse when ap_start is accepted
- ap_done  out  1  one-cycle pulse when the run completes
- ap_idle  out  1  high in IDLE only
- stage_mask  in  NUM_STAGES  bit i = run stage i; sampled at acceptance
- stage_start  out  NUM_STAGES  one-hot ap_start to the active stage
- stage_ready  in  NUM_STAGES  per-stage ap_ready
- stage_done  in  NUM_STAGES  per-stage ap_done
- cur_stage  out  IDX_W  index of active/last selected stage
- stage_cycles  out  NUM_STAGES*CNT_W  latched cycles per stage, stage i at [i*CNT_W +: CNT_W]
- total_cycles  out  CNT_W  cycles spent in non-IDLE states for the current/last run
- err_spurious  out  1  sticky: stage_done from a non-active stage

## Operation
- FSM states: IDLE, SELECT, START, WAIT_DONE, FINISH.
- IDLE: ap_idle=1. When ap_start=1:
  - pulse ap_ready;
  - latch stage_mask into pend_mask;
  - clear stage_cycles, total_cycles and err_spurious;
  - go to SELECT.
- SELECT:
  - If pend_mask==0, go to FINISH.
  - Otherwise load cur_stage with the lowest set bit of pend_mask and go to START.
- START:
  - stage_start[cur_stage]=1; all other bits are 0.
  - On stage_ready[cur_stage], deassert stage_start from the next cycle.
  - If stage_done[cur_stage] is also high in that cycle, complete the stage (see below) and go to SELECT. Otherwise go to WAIT_DONE.
- WAIT_DONE: on stage_done[cur_stage], complete the stage and go to SELECT.
- Stage completion:
  - latch the stage counter into stage_cycles[cur_stage];
  - clear pend_mask[cur_stage].
- FINISH: ap_done=1 for one cycle, then go to IDLE. ap_start is ignored in FINISH.
- Stage counter:
  - counts cycles from the first START cycle through the done cycle, inclusive;
  - saturates at 2^CNT_W−1.
- total_cycles:
  - increments in every SELECT, START, WAIT_DONE and FINISH cycle;
  - saturates;
  - holds its final value in IDLE until the next acceptance.
- err_spurious:
  - set when any stage_done[j] is high with j≠cur_stage in START/WAIT_DONE, or any stage_done bit is high in IDLE, SELECT or FINISH;
  - cleared only by reset or acceptance.
- Skipped stages keep stage_cycles=0. Changes to stage_mask during a run are ignored.

## Timing
- Reset values: state=IDLE; ap_idle=1; ap_ready, ap_done, stage_start, err_spurious = 0; cur_stage=0; stage_cycles=0; total_cycles=0; pend_mask=0.
- All outputs are registered or decoded from registered state. There is no combinational path from stage_done to stage_start.
- Acceptance at cycle 0 → SELECT at 1 → first stage_start at 2.
- Stage done at cycle t → SELECT at t+1 → next stage_start at t+2. Per-stage overhead is 2 cycles.
- stage_cycles[i] is visible from the cycle after that stage's done.
- Reset asserted mid-run: all outputs return to their reset values at the next edge, and stage_start drops immediately at that edge. A pending sub-stage handshake is abandoned.
- ap_start held high continuously → a new run is accepted on every IDLE cycle. Back-to-back runs are separated by exactly one IDLE cycle.

## Test plan
- Reset: hold reset 3 cycles mid-run with stage_start[2]=1 → next cycle all outputs at reset values, ap_idle=1, stage_start=0.
- Empty mask: stage_mask=0, pulse ap_start → ap_ready at cycle 0, ap_done at cycle 2, total_cycles=2, stage_start never asserted.
- Single stage: mask=5'b00100, stage_ready[2] at the first start cycle, stage_done[2] 3 cycles later → stage_cycles[2]=4, others 0, total_cycles=7, cur_stage=2.
- Full sequence: mask=5'b11111, each stage ready after 2 cycles and done after 10 → stages start strictly 0→4, each stage_cycles=10, ap_done exactly once.
- Ready+done same cycle: stage 1 asserts ready and done in its first START cycle → stage_cycles[1]=1, no WAIT_DONE visit, next stage_start 2 cycles later.
- Spurious/ordering: mask=5'b01010 with stage_done[0] pulsed during stage 1 WAIT_DONE → err_spurious=1 sticky, sequence unaffected, and err_spurious clears on the next ap_start acceptance.
